// File: rtl/fifo_pwm_player.sv
// rtl/fifo_pwm_player.sv - packed-sample FIFO to single-bit PWM audio player
module fifo_pwm_player #(
  parameter int SAMPLE_WIDTH     = 8,
  parameter int SAMPLES_PER_WORD = 4,
  parameter int FIFO_DATA_WIDTH  = SAMPLE_WIDTH * SAMPLES_PER_WORD,
  parameter int CLK_DIV          = 1,
  parameter int SIGNED_IN        = 0,
  parameter int UNDERRUN_MODE    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                       aud_pwm,
  output logic                       aud_sd,
  output logic                       sample_strobe,
  output logic                       underrun,
  output logic [15:0]                underrun_cnt
);
  localparam int SW     = SAMPLE_WIDTH;
  localparam int SLOT_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SAMPLES_PER_WORD - 1);
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(CLK_DIV - 1);
  localparam logic [SW-1:0]     MIDSCALE  = {1'b1, {(SW-1){1'b0}}};
  localparam logic [SW-1:0]     SIGN_MASK = (SIGNED_IN != 0) ? MIDSCALE : '0;

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;
  state_t state, state_next;

  logic [DIV_W-1:0]           div_cnt;
  logic [SW-1:0]              pwm_cnt;
  logic [SLOT_W-1:0]          slot, slot_next;
  logic [SW-1:0]              duty, next_sample, policy;
  logic [FIFO_DATA_WIDTH-1:0] cur_word, nxt_word, load_word;
  logic                       nxt_valid, rd_pending, starved;
  logic                       playing, tick, period_end, word_end;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = PRIME;
      PRIME:   if (nxt_valid) state_next = PLAY;
      default: state_next = PLAY;
    endcase
    if (!en) state_next = IDLE;
  end

  assign playing     = en && (state == PLAY);
  assign tick        = (div_cnt == LAST_DIV);
  assign period_end  = playing && tick && (pwm_cnt == '1);
  assign word_end    = period_end && (slot == LAST_SLOT);
  assign slot_next   = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
  // A read landing on the boundary cycle is consumed directly instead of via nxt_word.
  assign load_word   = rd_pending ? fifo_rd_data : nxt_word;
  assign next_sample = cur_word[slot_next*SW +: SW] ^ SIGN_MASK;
  assign policy      = (UNDERRUN_MODE != 0) ? MIDSCALE : duty;
  assign fifo_rd_en  = !rst && en && !fifo_empty && !nxt_valid && !rd_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      pwm_cnt       <= '0;
      slot          <= '0;
      duty          <= '0;
      cur_word      <= '0;
      nxt_word      <= '0;
      nxt_valid     <= 1'b0;
      rd_pending    <= 1'b0;
      starved       <= 1'b0;
      aud_pwm       <= 1'b0;
      aud_sd        <= 1'b0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
      underrun_cnt  <= '0;
    end else begin
      state         <= state_next;
      aud_sd        <= en;
      aud_pwm       <= playing && (pwm_cnt < duty);
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
      rd_pending    <= fifo_rd_en;
      if (rd_pending && !word_end) begin
        nxt_word  <= fifo_rd_data;
        nxt_valid <= 1'b1;
      end
      if (!en || state == IDLE) begin
        div_cnt  <= '0;
        pwm_cnt  <= '0;
        slot     <= '0;
        duty     <= '0;
        cur_word <= '0;
        starved  <= 1'b0;
      end else if (state == PRIME) begin
        if (nxt_valid) begin
          cur_word      <= nxt_word;
          nxt_valid     <= 1'b0;
          duty          <= nxt_word[SW-1:0] ^ SIGN_MASK;
          sample_strobe <= 1'b1;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) pwm_cnt <= pwm_cnt + 1'b1;
        if (period_end) begin
          slot          <= slot_next;
          sample_strobe <= 1'b1;
          if (word_end) begin
            if (rd_pending || nxt_valid) begin
              cur_word <= load_word;
              starved  <= 1'b0;
              duty     <= load_word[SW-1:0] ^ SIGN_MASK;
              if (!rd_pending) nxt_valid <= 1'b0;
            end else begin
              underrun <= 1'b1;
              starved  <= 1'b1;
              duty     <= policy;
              if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
            end
          end else begin
            duty <= starved ? policy : next_sample;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_pwm_player.sv
// tb/tb_fifo_pwm_player.sv - randomized self-checking bench for fifo_pwm_player
module tb_fifo_pwm_player;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  // DUT A: defaults. DUT B: signed input, midscale underrun, CLK_DIV 3, two slots.
  localparam int PA = 256;
  localparam int PB = 768;

  logic        fifo_empty_a, fifo_rd_en_a, aud_pwm_a, aud_sd_a, sample_strobe_a, underrun_a;
  logic [31:0] fifo_rd_data_a = '0;
  logic [15:0] underrun_cnt_a;
  logic        fifo_empty_b, fifo_rd_en_b, aud_pwm_b, aud_sd_b, sample_strobe_b, underrun_b;
  logic [15:0] fifo_rd_data_b = '0;
  logic [15:0] underrun_cnt_b;

  fifo_pwm_player dut_a (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty_a), .fifo_rd_en(fifo_rd_en_a),
    .fifo_rd_data(fifo_rd_data_a), .aud_pwm(aud_pwm_a), .aud_sd(aud_sd_a),
    .sample_strobe(sample_strobe_a), .underrun(underrun_a), .underrun_cnt(underrun_cnt_a)
  );

  fifo_pwm_player #(
    .SAMPLE_WIDTH(8), .SAMPLES_PER_WORD(2), .FIFO_DATA_WIDTH(16), .CLK_DIV(3),
    .SIGNED_IN(1), .UNDERRUN_MODE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty_b), .fifo_rd_en(fifo_rd_en_b),
    .fifo_rd_data(fifo_rd_data_b), .aud_pwm(aud_pwm_b), .aud_sd(aud_sd_b),
    .sample_strobe(sample_strobe_b), .underrun(underrun_b), .underrun_cnt(underrun_cnt_b)
  );

  // FIFO models: written only by the initial block, read only by the pop process.
  logic [31:0] mem_a [0:15];
  logic [15:0] mem_b [0:15];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0, pop_err = 0;
  assign fifo_empty_a = (wr_a == rd_a);
  assign fifo_empty_b = (wr_b == rd_b);

  always @(posedge clk) begin
    if (fifo_rd_en_a) begin
      if (rd_a != wr_a) begin fifo_rd_data_a <= mem_a[rd_a]; rd_a <= rd_a + 1; end
      else pop_err <= pop_err + 1;
    end
    if (fifo_rd_en_b) begin
      if (rd_b != wr_b) begin fifo_rd_data_b <= mem_b[rd_b]; rd_b <= rd_b + 1; end
      else pop_err <= pop_err + 1;
    end
  end

  // Observation: high clocks per period, strobe spacing, underrun times and counts.
  int cyc = 0;
  int obs_a[$], obs_b[$], gap_a[$], gap_b[$], urc_a[$], urc_b[$], urn_a[$], urn_b[$];
  int cnt_a = 0, cnt_b = 0, last_a = 0, last_b = 0, first_a = -1, first_b = -1;
  bit open_a = 0, open_b = 0;

  always @(negedge clk) begin
    cyc++;
    if (!aud_sd_a) open_a = 0;
    else if (sample_strobe_a) begin
      if (open_a) begin obs_a.push_back(cnt_a); gap_a.push_back(cyc - last_a); end
      if (first_a < 0) first_a = cyc;
      open_a = 1; cnt_a = int'(aud_pwm_a); last_a = cyc;
    end else if (open_a) cnt_a += int'(aud_pwm_a);
    if (underrun_a) begin urc_a.push_back(cyc); urn_a.push_back(int'(underrun_cnt_a)); end
    if (!aud_sd_b) open_b = 0;
    else if (sample_strobe_b) begin
      if (open_b) begin obs_b.push_back(cnt_b); gap_b.push_back(cyc - last_b); end
      if (first_b < 0) first_b = cyc;
      open_b = 1; cnt_b = int'(aud_pwm_b); last_b = cyc;
    end else if (open_b) cnt_b += int'(aud_pwm_b);
    if (underrun_b) begin urc_b.push_back(cyc); urn_b.push_back(int'(underrun_cnt_b)); end
  end

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string tag, input longint observed, input longint expected);
    n_chk++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  function automatic int byte_of(input logic [31:0] w, input int s);
    return int'((w >> (8 * s)) & 32'hFF);
  endfunction

  task automatic push_a(input logic [31:0] w);
    mem_a[wr_a] = w; wr_a++;
  endtask

  task automatic push_b(input logic [15:0] w);
    mem_b[wr_b] = w; wr_b++;
  endtask

  logic [31:0] wa [0:2];
  logic [15:0] wb [0:2];
  logic [31:0] ref_a, w2_a, w3_a;
  logic [15:0] ref_b;
  int exp_a[$], exp_b[$];
  int base, n1a, n1b;
  bit refilled_a = 0, refilled_b = 0;

  initial begin
    wa[0] = 32'h40FF_0080; wa[1] = $urandom; wa[2] = $urandom;
    wb[0] = 16'h7F80;      wb[1] = 16'($urandom); wb[2] = 16'($urandom);
    ref_a = $urandom; ref_b = 16'($urandom); w2_a = $urandom; w3_a = $urandom;

    // Reference playback: each sample lasts one period; high clocks = duty * CLK_DIV.
    for (int w = 0; w < 3; w++) for (int s = 0; s < 4; s++) exp_a.push_back(byte_of(wa[w], s));
    for (int s = 0; s < 4; s++) exp_a.push_back(byte_of(wa[2], 3));
    for (int s = 0; s < 4; s++) exp_a.push_back(byte_of(ref_a, s));
    for (int s = 0; s < 24; s++) exp_a.push_back(byte_of(ref_a, 3));
    for (int w = 0; w < 3; w++) for (int s = 0; s < 2; s++) exp_b.push_back(3 * (byte_of({16'h0, wb[w]}, s) ^ 128));
    for (int s = 0; s < 2; s++) exp_b.push_back(3 * 128);
    for (int s = 0; s < 2; s++) exp_b.push_back(3 * (byte_of({16'h0, ref_b}, s) ^ 128));
    for (int s = 0; s < 10; s++) exp_b.push_back(3 * 128);

    repeat (3) @(negedge clk);
    chk("rst_aud_pwm_a", aud_pwm_a, 0);
    chk("rst_aud_sd_a", aud_sd_a, 0);
    chk("rst_strobe_a", sample_strobe_a, 0);
    chk("rst_underrun_a", underrun_a, 0);
    chk("rst_underrun_cnt_a", underrun_cnt_a, 0);
    chk("rst_rd_en_b", fifo_rd_en_b, 0);
    chk("rst_underrun_cnt_b", underrun_cnt_b, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin push_a(wa[i]); push_b(wb[i]); end
    en = 1'b1;

    // Phase 1: three words each, drain, one refill pushed on the first underrun.
    for (int c = 0; c < 9000; c++) begin
      @(negedge clk);
      if (underrun_a && !refilled_a) begin push_a(ref_a); refilled_a = 1; end
      if (underrun_b && !refilled_b) begin push_b(ref_b); refilled_b = 1; end
    end
    chk("aud_sd_follows_en", aud_sd_a, 1);
    chk("a_enough_periods", obs_a.size() >= 30, 1);
    chk("b_enough_periods", obs_b.size() >= 10, 1);
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++)
      chk($sformatf("a_period_%0d", i), obs_a[i], exp_a[i]);
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++)
      chk($sformatf("b_period_%0d", i), obs_b[i], exp_b[i]);
    n1a = urc_a.size(); n1b = urc_b.size();
    chk("a_underrun_events", n1a >= 4, 1);
    chk("b_underrun_events", n1b >= 2, 1);
    for (int k = 0; k < n1a; k++) begin
      chk($sformatf("a_underrun_time_%0d", k), urc_a[k] - first_a,
          (k == 0) ? 12 * PA : 20 * PA + (k - 1) * 4 * PA);
      chk($sformatf("a_underrun_cnt_%0d", k), urn_a[k], k + 1);
    end
    for (int k = 0; k < n1b; k++) begin
      chk($sformatf("b_underrun_time_%0d", k), urc_b[k] - first_b,
          (k == 0) ? 6 * PB : 10 * PB + (k - 1) * 2 * PB);
      chk($sformatf("b_underrun_cnt_%0d", k), urn_b[k], k + 1);
    end
    chk("a_one_pop_per_word", rd_a, 4);
    chk("b_one_pop_per_word", rd_b, 4);
    chk("no_pop_on_empty", pop_err, 0);

    // Phase 2: drop en while a read is in flight; the popped word must survive.
    @(negedge clk);
    push_a(w2_a); push_a(w3_a);
    #1 chk("a_rd_issue", fifo_rd_en_a, 1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("endrop_aud_pwm_a", aud_pwm_a, 0);
    chk("endrop_aud_pwm_b", aud_pwm_b, 0);
    chk("endrop_aud_sd_a", aud_sd_a, 0);
    repeat (20) @(negedge clk);
    chk("endrop_rd_en_a", fifo_rd_en_a, 0);
    chk("endrop_w3_still_queued", wr_a - rd_a, 1);
    chk("endrop_underrun_cnt_kept", underrun_cnt_a, urc_a.size());
    base = obs_a.size();
    en = 1'b1;
    repeat (2600) @(negedge clk);
    chk("reenable_periods", obs_a.size() >= base + 8, 1);
    for (int i = 0; i < 8 && base + i < obs_a.size(); i++)
      chk($sformatf("reenable_period_%0d", i), obs_a[base + i],
          byte_of((i < 4) ? w2_a : w3_a, i % 4));
    chk("reenable_all_popped", rd_a, wr_a);

    // Phase 3: reset in the middle of playback.
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_aud_pwm_a", aud_pwm_a, 0);
    chk("midrst_strobe_a", sample_strobe_a, 0);
    chk("midrst_underrun_cnt_a", underrun_cnt_a, 0);
    chk("midrst_underrun_cnt_b", underrun_cnt_b, 0);
    rst = 1'b0;
    en  = 1'b0;

    for (int i = 0; i < gap_a.size(); i++) chk($sformatf("a_strobe_gap_%0d", i), gap_a[i], PA);
    for (int i = 0; i < gap_b.size(); i++) chk($sformatf("b_strobe_gap_%0d", i), gap_b[i], PB);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
